// File: rtl/caravel_clock_divmon.sv
// caravel_clock_divmon: glitch-free programmable core/user clock dividers with a windowed edge-count frequency monitor.
module caravel_clock_divmon #(
    parameter int DIV_W        = 3,
    parameter int CNT_W        = 16,
    parameter int DEF_CORE_DIV = 4,
    parameter int DEF_USER_DIV = 4
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic [DIV_W-1:0] core_div_i,
    input  logic [DIV_W-1:0] user_div_i,
    input  logic             div_load_i,
    input  logic             meas_start_i,
    input  logic [CNT_W-1:0] meas_window_i,
    output logic             core_clk_o,
    output logic             user_clk_o,
    output logic             core_tick_o,
    output logic             user_tick_o,
    output logic             meas_busy_o,
    output logic             meas_done_o,
    output logic [CNT_W-1:0] core_count_o,
    output logic [CNT_W-1:0] user_count_o
);
    typedef logic [DIV_W-1:0] div_t;
    div_t       req [2];
    div_t       div_q [2], div_d [2], pend_q [2], pend_d [2], p_q [2], p_d [2];
    logic [1:0] clk_q, clk_d, tick_q, tick_d;
    logic             busy_q, done_q;
    logic [CNT_W-1:0] w_q, cc_q, uc_q, core_count_q, user_count_q, cc_d, uc_d;

    assign req[0] = core_div_i;
    assign req[1] = user_div_i;

    // Index 0 is the core channel, 1 the user channel.
    // A new divisor is adopted only on a wrap (or while stopped), so no phase is ever cut short.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            pend_d[c] = div_load_i ? ((req[c] < div_t'(2)) ? div_t'(2) : req[c]) : pend_q[c];
            div_d[c]  = div_q[c];
            p_d[c]    = p_q[c];
            clk_d[c]  = 1'b0;
            tick_d[c] = 1'b0;
            if (!enable_i) begin
                div_d[c] = pend_q[c];
                p_d[c]   = pend_q[c] - 1'b1;
            end else if (p_q[c] >= div_q[c] - 1'b1) begin
                div_d[c]  = pend_q[c];
                p_d[c]    = '0;
                clk_d[c]  = 1'b1;
                tick_d[c] = 1'b1;
            end else begin
                p_d[c]   = p_q[c] + 1'b1;
                clk_d[c] = {1'b0, p_d[c]} < (({1'b0, div_q[c]} + 1'b1) >> 1);
            end
        end
    end

    assign cc_d = (&cc_q) ? cc_q : cc_q + CNT_W'(tick_q[0]);
    assign uc_d = (&uc_q) ? uc_q : uc_q + CNT_W'(tick_q[1]);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            div_q[0]     <= DIV_W'(DEF_CORE_DIV);
            div_q[1]     <= DIV_W'(DEF_USER_DIV);
            pend_q[0]    <= DIV_W'(DEF_CORE_DIV);
            pend_q[1]    <= DIV_W'(DEF_USER_DIV);
            p_q[0]       <= DIV_W'(DEF_CORE_DIV - 1);
            p_q[1]       <= DIV_W'(DEF_USER_DIV - 1);
            clk_q        <= '0;
            tick_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            w_q          <= '0;
            cc_q         <= '0;
            uc_q         <= '0;
            core_count_q <= '0;
            user_count_q <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                div_q[c]  <= div_d[c];
                pend_q[c] <= pend_d[c];
                p_q[c]    <= p_d[c];
            end
            clk_q  <= clk_d;
            tick_q <= tick_d;
            done_q <= 1'b0;
            if (!busy_q) begin
                if (meas_start_i) begin
                    busy_q <= 1'b1;
                    cc_q   <= '0;
                    uc_q   <= '0;
                    w_q    <= (meas_window_i == '0) ? CNT_W'(1) : meas_window_i;
                end
            end else begin
                cc_q <= cc_d;
                uc_q <= uc_d;
                w_q  <= w_q - 1'b1;
                if (w_q == CNT_W'(1)) begin
                    busy_q       <= 1'b0;
                    done_q       <= 1'b1;
                    core_count_q <= cc_d;
                    user_count_q <= uc_d;
                end
            end
        end
    end

    assign core_clk_o   = clk_q[0];
    assign user_clk_o   = clk_q[1];
    assign core_tick_o  = tick_q[0];
    assign user_tick_o  = tick_q[1];
    assign meas_busy_o  = busy_q;
    assign meas_done_o  = done_q;
    assign core_count_o = core_count_q;
    assign user_count_o = user_count_q;
endmodule

// File: tb/tb_caravel_clock_divmon.sv
// tb_caravel_clock_divmon: directed checks of divider waveforms, divisor switching, enable gating and the frequency monitor.
module tb_caravel_clock_divmon;
    logic        clock, reset, enable, div_load, meas_start;
    logic [2:0]  core_div, user_div;
    logic [15:0] meas_window;
    logic        core_clk, user_clk, core_tick, user_tick, meas_busy, meas_done;
    logic [15:0] core_count, user_count;
    int          n_cmp = 0, n_bad = 0;

    caravel_clock_divmon dut (
        .clock_i(clock), .reset_i(reset), .enable_i(enable),
        .core_div_i(core_div), .user_div_i(user_div), .div_load_i(div_load),
        .meas_start_i(meas_start), .meas_window_i(meas_window),
        .core_clk_o(core_clk), .user_clk_o(user_clk),
        .core_tick_o(core_tick), .user_tick_o(user_tick),
        .meas_busy_o(meas_busy), .meas_done_o(meas_done),
        .core_count_o(core_count), .user_count_o(user_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_tick(input bit user, input int lim);
        int n = 0;
        while (((user ? user_tick : core_tick) !== 1'b1) && n < lim) begin
            @(negedge clock);
            n++;
        end
        check(user ? "sync_user_tick" : "sync_core_tick", user ? user_tick : core_tick, 1);
    endtask

    task automatic wait_done(input string tag, input int lim);
        int n = 0;
        while (meas_done !== 1'b1 && n < lim) begin
            @(negedge clock);
            n++;
        end
        check(tag, meas_done, 1);
    endtask

    task automatic rec(input bit user, input int len, output logic [31:0] v);
        v = '0;
        for (int i = 0; i < len; i++) begin
            v = {v[30:0], user ? user_clk : core_clk};
            @(negedge clock);
        end
    endtask

    task automatic load_div(input logic [2:0] c, input logic [2:0] u);
        core_div = c;
        user_div = u;
        div_load = 1'b1;
        @(negedge clock);
        div_load = 1'b0;
    endtask

    task automatic start_meas(input logic [15:0] w);
        meas_window = w;
        meas_start  = 1'b1;
        @(negedge clock);
        meas_start  = 1'b0;
    endtask

    initial begin
        logic [31:0] v, cv, uv, ct, ut;
        int pulses;
        reset = 1'b1; enable = 1'b1; div_load = 1'b0; meas_start = 1'b0;
        core_div = 3'd0; user_div = 3'd0; meas_window = 16'd0;
        repeat (2) @(negedge clock);
        check("rst_core_clk", core_clk, 0);
        check("rst_user_clk", user_clk, 0);
        check("rst_ticks", {core_tick, user_tick}, 0);
        check("rst_busy_done", {meas_busy, meas_done}, 0);
        check("rst_counts", {core_count, user_count}, 0);

        // Defaults N=4: rising immediately after reset, 1100 repeating, ticks aligned
        reset = 1'b0;
        @(negedge clock);
        cv = '0; uv = '0; ct = '0; ut = '0;
        for (int i = 0; i < 8; i++) begin
            cv = {cv[30:0], core_clk};  uv = {uv[30:0], user_clk};
            ct = {ct[30:0], core_tick}; ut = {ut[30:0], user_tick};
            @(negedge clock);
        end
        check("def_core_wave", cv, 32'b11001100);
        check("def_user_wave", uv, 32'b11001100);
        check("def_core_tick", ct, 32'b10001000);
        check("def_user_tick", ut, 32'b10001000);

        // core=7, user=1 (clamped to 2)
        load_div(3'd7, 3'd1);
        repeat (20) @(negedge clock);
        wait_tick(1'b0, 20);
        rec(1'b0, 14, v);
        check("div7_core_wave", v, 32'b11110001111000);
        wait_tick(1'b1, 20);
        rec(1'b1, 8, v);
        check("div1_user_wave", v, 32'b10101010);
        start_meas(16'd700);
        check("m700_busy", meas_busy, 1);
        repeat (10) @(negedge clock);
        start_meas(16'd5);
        wait_done("m700_done", 800);
        check("m700_core_count", core_count, 100);
        check("m700_user_count", user_count, 350);
        @(negedge clock);
        check("m700_done_pulse", {meas_busy, meas_done}, 0);

        // Window of 0 behaves as 1 cycle
        start_meas(16'd0);
        check("w0_busy", {meas_busy, meas_done}, 2'b10);
        @(negedge clock);
        check("w0_done", {meas_busy, meas_done}, 2'b01);

        load_div(3'd4, 3'd4);
        repeat (20) @(negedge clock);
        start_meas(16'd1000);
        wait_done("m1000_done", 1100);
        check("m1000_core_count", core_count, 250);
        check("m1000_user_count", user_count, 250);

        // Reset mid-window aborts the measurement and clears counts
        start_meas(16'd100);
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_busy_done", {meas_busy, meas_done}, 0);
        check("abort_counts", {core_count, user_count}, 0);
        pulses = 0;
        repeat (150) begin
            @(negedge clock);
            if (meas_done === 1'b1) pulses++;
        end
        check("abort_no_done", pulses, 0);

        // 4->2 loaded during the high phase: old period completes, then 10 10
        wait_tick(1'b0, 20);
        v = '0;
        for (int i = 0; i < 10; i++) begin
            v = {v[30:0], core_clk};
            if (i == 0) begin core_div = 3'd2; user_div = 3'd2; div_load = 1'b1; end
            if (i == 1) div_load = 1'b0;
            @(negedge clock);
        end
        check("switch_4to2_wave", v, 32'b1100101010);

        // Disable for 10 cycles across a 10-cycle window: no counts, clocks rise on re-enable
        enable = 1'b0;
        meas_window = 16'd10;
        meas_start = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            meas_start = 1'b0;
            if (i == 5) check("dis_clks_low", {core_clk, user_clk, core_tick, user_tick}, 0);
        end
        enable = 1'b1;
        @(negedge clock);
        check("dis_done", meas_done, 1);
        check("dis_counts", {core_count, user_count}, 0);
        check("en_rise", {core_clk, user_clk, core_tick, user_tick}, 4'b1111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
